ps2_mouse_packer: RTL and testbench

//  Producer side of the 25-bit ps2_mouse word consumed by paddle_ctl and other mouse users.

---
 rtl/ps2_mouse_packer.sv | 94 +++++++++
 tb/tb_ps2_mouse_packer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_packer.sv
// Assembles the three PS/2 mouse bytes (flags, X, Y) into the 25-bit ps2_mouse word.
// Malformed or stalled packets are dropped, and pkt_drop pulses for one cycle.
module ps2_mouse_packer #(
  parameter int TIMEOUT = 50000,
  parameter int TW      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        byte_err,
  output logic [24:0] ps2_mouse,
  output logic        pkt_drop
);

  typedef enum logic [1:0] {B0, B1, B2} state_t;

  localparam logic [TW-1:0] TERM_CNT = TW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [TW-1:0] cnt_reg, cnt_next;
  logic [7:0]    flags_reg, flags_next;
  logic [7:0]    x_reg, x_next;
  logic [24:0]   mouse_next;
  logic          drop_next;
  logic          accept;

  assign accept = byte_valid & ~byte_err;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= B0;
      cnt_reg   <= '0;
      flags_reg <= '0;
      x_reg     <= '0;
      ps2_mouse <= '0;
      pkt_drop  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      flags_reg <= flags_next;
      x_reg     <= x_next;
      ps2_mouse <= mouse_next;
      pkt_drop  <= drop_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    flags_next = flags_reg;
    x_next     = x_reg;
    mouse_next = ps2_mouse;
    drop_next  = 1'b0;
    case (state_reg)
      B0: begin
        cnt_next = '0;
        // Only a byte with bit 3 set can start a packet; anything else is resync noise.
        if (accept && byte_data[3]) begin
          flags_next = byte_data;
          state_next = B1;
        end
      end
      B1, B2: begin
        if (accept) begin
          cnt_next = '0;
          if (state_reg == B1) begin
            x_next     = byte_data;
            state_next = B2;
          end else begin
            // Overflow bits zero the affected delta; flags go out untouched.
            mouse_next = {~ps2_mouse[24],
                          flags_reg[7] ? 8'h00 : byte_data,
                          flags_reg[6] ? 8'h00 : x_reg,
                          flags_reg};
            state_next = B0;
          end
        end else if (byte_valid || cnt_reg == TERM_CNT) begin
          // A bad byte or a stall of TIMEOUT cycles abandons the partial packet.
          cnt_next   = '0;
          drop_next  = 1'b1;
          state_next = B0;
        end else begin
          cnt_next = cnt_reg + TW'(1);
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = B0;
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_mouse_packer.sv
// Self-checking bench for ps2_mouse_packer: directed scenarios plus random byte traffic,
// compared every cycle against a packet-level model built from byte queues and timestamps.
module tb_ps2_mouse_packer;

  localparam int TIMEOUT = 20;
  localparam int TW      = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_err = 1'b0;
  logic [24:0] ps2_mouse;
  logic        pkt_drop;

  ps2_mouse_packer #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .ps2_mouse  (ps2_mouse),
    .pkt_drop   (pkt_drop)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          drops    = 0;
  int          cyc      = 0;
  int          last_acc = 0;
  logic [7:0]  pkt_q[$];
  logic [24:0] exp_mouse = '0;
  logic        exp_drop  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Packet-level reference: a byte queue plus the cycle of the last accepted byte.
  task automatic model(input logic v, input logic e, input logic [7:0] d);
    logic [7:0] f, x;
    exp_drop = 1'b0;
    if (pkt_q.size() == 0) begin
      if (v && !e && d[3]) begin
        pkt_q.push_back(d);
        last_acc = cyc;
      end
    end else if (v && !e) begin
      pkt_q.push_back(d);
      last_acc = cyc;
      if (pkt_q.size() == 3) begin
        f = pkt_q[0];
        x = pkt_q[1];
        exp_mouse = {~exp_mouse[24], f[7] ? 8'h00 : d, f[6] ? 8'h00 : x, f};
        pkt_q.delete();
      end
    end else if (v || (cyc - last_acc >= TIMEOUT)) begin
      pkt_q.delete();
      exp_drop = 1'b1;
    end
  endtask

  task automatic step(input logic v, input logic e, input logic [7:0] d);
    byte_valid = v;
    byte_err   = e;
    byte_data  = d;
    model(v, e, d);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    check_eq("ps2_mouse", 32'(ps2_mouse), 32'(exp_mouse));
    check_eq("pkt_drop", 32'(pkt_drop), 32'(exp_drop));
    if (pkt_drop) begin
      drops++;
      $display("cycle %0d: packet dropped", cyc);
    end
    if (exp_drop == 1'b0 && v && !e && pkt_q.size() == 0 && ps2_mouse != 25'h0)
      $display("cycle %0d: byte %h, ps2_mouse=%h", cyc, d, ps2_mouse);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, 1'b0, d);
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    @(posedge clk);
    #1;
    pkt_q.delete();
    exp_mouse = '0;
    exp_drop  = 1'b0;
    check_eq("reset_mouse", 32'(ps2_mouse), 32'h0);
    check_eq("reset_drop", 32'(pkt_drop), 32'h0);
    $display("cycle %0d: reset", cyc);
    reset_n = 1'b1;
    cyc++;
  endtask

  initial begin
    int d0;
    logic [24:0] saved;
    do_reset();
    do_reset();

    // Spaced packet from reset, then a second packet toggling bit 24 back.
    send(8'h09); idle(9); send(8'h05); idle(9); send(8'hFB);
    check_eq("t1_pkt1", 32'(ps2_mouse), 32'h1FB0509);
    send(8'h08); send(8'h00); send(8'h00);
    check_eq("t1_pkt2", 32'(ps2_mouse), 32'h0000008);

    // Resync: a leading byte without bit 3 is ignored silently.
    d0 = drops;
    send(8'h05); send(8'h09); send(8'h01); send(8'h02);
    check_eq("t2_pkt", 32'(ps2_mouse), 32'h1020109);
    check_eq("t2_drops", 32'(drops - d0), 32'h0);

    // Stall after X byte: one drop pulse, then the next packet goes through.
    d0 = drops;
    send(8'h09); send(8'h10); idle(TIMEOUT + 2);
    check_eq("t3_drops", 32'(drops - d0), 32'h1);
    send(8'h0A); send(8'h01); send(8'h01);
    check_eq("t3_pkt", 32'(ps2_mouse[23:0]), 32'h01010A);

    // Y byte on the terminal-count cycle wins over the timeout.
    d0 = drops;
    send(8'h09); send(8'h01); idle(TIMEOUT - 1); send(8'h02);
    check_eq("t4_pkt", 32'(ps2_mouse[23:0]), 32'h020109);
    idle(2);
    check_eq("t4_drops", 32'(drops - d0), 32'h0);

    // Errored X byte drops the packet without touching ps2_mouse.
    d0 = drops;
    saved = exp_mouse;
    send(8'h09); step(1'b1, 1'b1, 8'h33);
    check_eq("t5_drops", 32'(drops - d0), 32'h1);
    check_eq("t5_hold", 32'(ps2_mouse), 32'(saved));
    send(8'h09); send(8'h01); send(8'h02);
    check_eq("t5_pkt", 32'(ps2_mouse[23:0]), 32'h020109);

    // Overflow flags zero both deltas, then reset mid-packet.
    send(8'hC8); send(8'h7F); send(8'h80);
    check_eq("t6_ovf", 32'(ps2_mouse[23:0]), 32'h0000C8);
    d0 = drops;
    send(8'h09); send(8'h01);
    do_reset();
    idle(3);
    check_eq("t6_drops", 32'(drops - d0), 32'h0);
    send(8'h09); send(8'h01); send(8'h02);
    check_eq("t6_pkt", 32'(ps2_mouse), 32'h1020109);

    // Random traffic: bursts, errors, noise bytes and long stalls.
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) d[3] = 1'b1;
      if (r < 3) idle($urandom_range(TIMEOUT - 3, TIMEOUT + 3));
      else step(r < 60, $urandom_range(0, 15) == 0, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
